axi_copy_dma: RTL
=================

Name: axi_copy_dma

Overview:
- Single-channel AXI4 memory-to-memory copy engine; the master that drives the hostMem slave port of the simulated device memory.
- Accepts a copy command (source, destination, length in beats) and moves the data in INCR bursts through an internal burst buffer: read burst, then write burst, repeated until done.
- Reports completion and error status to the accelerator control logic.

Parameters:
DATA_WIDTH, 32, AXI data width in bits; power of two, at least 8
ADDR_WIDTH, 16, AXI address width in bits
ID_WIDTH, 8, AXI ID width
AXI_ID, 0, constant ID driven on arid/awid
MAX_BURST, 16, maximum beats per burst and buffer depth; power of two, 1..256
LEN_WIDTH, 16, width of the command beat count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  engine idle, can accept a command
cmd_src  in  ADDR_WIDTH  source byte address, beat-aligned
cmd_dst  in  ADDR_WIDTH  destination byte address, beat-aligned
cmd_len  in  LEN_WIDTH  number of beats to copy
done  out  1  one-cycle completion pulse
err  out  1  status of last command, valid with done, held until next accept
m_ar*/m_r*  AXI4 read channels: arvalid/arready/arid/araddr/arlen[8]/arsize[3]/arburst[2]/arlock/arcache[4]/arprot[3]; rvalid/rready/rid/rdata/rresp[2]/rlast
m_aw*/m_w*/m_b*  AXI4 write channels: awvalid/awready/awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot; wvalid/wready/wdata/wstrb/wlast; bvalid/bready/bid/bresp

Behaviour:
- Reset (async assert, sync release): state IDLE; cmd_ready=1; done=0; err=0; all AXI valids and readies 0.
- Constant AXI fields: arsize/awsize=log2(DATA_WIDTH/8); burst=2'b01 (INCR); lock=0; cache=4'b0011; prot=0; wstrb all ones; id=AXI_ID.
- Handshake rules:
  - Transfer occurs on valid&&ready.
  - Once asserted, valid and payload are held until accepted.
  - No combinational path from any ready to any valid.
- States: IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, FIN.
- IDLE: cmd_ready=1. On cmd_valid, latch src/dst/len and go to RADDR; cmd_len=0 goes to FIN with err=0.
- Burst sizing: beats = min(remaining, MAX_BURST, beats until next 4 KB boundary of the current source address). arlen=beats-1.
  - The write burst reuses the same beat count.
  - A write burst that would cross 4 KB at dst is split further by taking the minimum against the dst boundary as well; one common count covers both bursts.
- RADDR: arvalid=1 with araddr=src. On accept, go to RDATA.
  - arvalid rises the cycle after command accept; minimum latency of 1.
- RDATA: rready=1. Each beat is written to buffer[index].
  - rresp!=0 sets sticky err.
  - On the beat with rlast (or the final expected beat): go to WADDR if err=0, else FIN.
  - All beats of the burst are always drained, including after an error.
- WADDR: awvalid=1 with awaddr=dst. On accept, go to WDATA.
- WDATA: wvalid=1, wdata=buffer[index], wlast on beat beats-1. After the last accepted beat, go to WRESP.
- WRESP: bready=1. On bvalid:
  - bresp!=0 sets err.
  - src += beats*bytes, dst += beats*bytes, remaining -= beats.
  - Go to FIN if remaining==0 or err, else RADDR.
- FIN: done=1 for exactly one cycle, then IDLE. err is held until the next command accept, where it clears.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error is flagged on wrap.
- Exactly one outstanding transaction; reads and writes never overlap.
- rid/bid are ignored.
- Reset asserted mid-transfer aborts immediately to the reset state. The bench must also reset the slave.

Test Plan:
- len=4, src=0x0000, dst=0x0100 after preloading 4 words -> one AR with arlen=3; 4 R beats; one AW addr 0x0100, arlen/awlen=3; wlast on beat 3; done pulse; err=0; destination matches source.
- len=40, MAX_BURST=16 -> bursts of 16, 16, 8 beats; addresses advance by 64 B each; a single done pulse after the third B.
- src=0x0FF8, len=4, 32-bit data -> first burst 2 beats (ending at 4 KB), second burst 2 beats at 0x1000; data intact.
- Slave returns rresp=2'b10 on beat 1 of 4 -> remaining beats drained; no AW issued; done with err=1. The next command clears err.
- Random arready/rvalid/awready/wready/bvalid stalls on a 64-beat copy -> valids stable under backpressure, no beat lost or duplicated, memory matches.
- cmd_len=0 -> no AXI activity; done 2 cycles after accept; err=0. rst_n pulsed mid-WDATA -> all valids 0 immediately, cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_copy_dma.sv
// axi_copy_dma: single-channel AXI4 memory-to-memory copy engine.
// Ports: cmd_* command in, done/err status out, m_ar/r/aw/w/b AXI4 master.
module axi_copy_dma #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_src,
  input  logic [ADDR_WIDTH-1:0]   cmd_dst,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  output logic                    done,
  output logic                    err,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [ID_WIDTH-1:0]     m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arlock,
  output logic [3:0]              m_arcache,
  output logic [2:0]              m_arprot,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  input  logic [ID_WIDTH-1:0]     m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [ID_WIDTH-1:0]     m_awid,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awlock,
  output logic [3:0]              m_awcache,
  output logic [2:0]              m_awprot,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wlast,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  input  logic [ID_WIDTH-1:0]     m_bid,
  input  logic [1:0]              m_bresp
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, FIN
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   src;
  logic [ADDR_WIDTH-1:0]   dst;
  logic [LEN_WIDTH-1:0]    rem;
  logic [7:0]              blen;
  logic [IW-1:0]           idx;
  logic [DATA_WIDTH-1:0]   buf_q [2**IW];

  logic [8:0]              beats;
  logic [ADDR_WIDTH-1:0]   step;
  logic [ADDR_WIDTH-1:0]   nsrc;
  logic [ADDR_WIDTH-1:0]   ndst;
  logic [LEN_WIDTH-1:0]    nrem;
  logic [IW-1:0]           idx_inc;
  logic                    r_last;
  logic                    b_err;
  logic                    unused_ids;

  // One beat count serves both bursts, so it is clipped
  // against the 4 KB page of the source and destination.
  function automatic logic [7:0] burst_len(
    input logic [LEN_WIDTH-1:0] left,
    input logic [11:0]          sa,
    input logic [11:0]          da
  );
    logic [31:0] n, ps, pd;
    n  = 32'(left);
    ps = (32'd4096 - 32'(sa)) >> SZ;
    pd = (32'd4096 - 32'(da)) >> SZ;
    if (n > 32'(MAX_BURST)) n = 32'(MAX_BURST);
    if (ps < n) n = ps;
    if (pd < n) n = pd;
    return 8'(n - 32'd1);
  endfunction

  assign m_arid    = ID_WIDTH'(AXI_ID);
  assign m_awid    = ID_WIDTH'(AXI_ID);
  assign m_araddr  = src;
  assign m_awaddr  = dst;
  assign m_arlen   = blen;
  assign m_awlen   = blen;
  assign m_arsize  = 3'(SZ);
  assign m_awsize  = 3'(SZ);
  assign m_arburst = 2'b01;
  assign m_awburst = 2'b01;
  assign m_arlock  = 1'b0;
  assign m_awlock  = 1'b0;
  assign m_arcache = 4'b0011;
  assign m_awcache = 4'b0011;
  assign m_arprot  = 3'b000;
  assign m_awprot  = 3'b000;
  assign m_wstrb   = '1;
  assign m_wdata   = buf_q[idx];
  assign unused_ids = ^{m_rid, m_bid};

  always_comb begin
    beats   = {1'b0, blen} + 9'd1;
    step    = ADDR_WIDTH'(beats) << SZ;
    nsrc    = src + step;
    ndst    = dst + step;
    nrem    = rem - LEN_WIDTH'(beats);
    idx_inc = idx + IW'(1);
    r_last  = m_rlast || (idx == blen[IW-1:0]);
    b_err   = err || (m_bresp != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (state == RDATA && m_rvalid && m_rready)
      buf_q[idx] <= m_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      src       <= '0;
      dst       <= '0;
      rem       <= '0;
      blen      <= '0;
      idx       <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_wlast   <= 1'b0;
      m_bready  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (cmd_valid) begin
          cmd_ready <= 1'b0;
          err       <= 1'b0;
          src       <= cmd_src;
          dst       <= cmd_dst;
          rem       <= cmd_len;
          blen      <= burst_len(cmd_len, cmd_src[11:0],
                                 cmd_dst[11:0]);
          if (cmd_len == '0) begin
            state <= FIN;
          end else begin
            state     <= RADDR;
            m_arvalid <= 1'b1;
          end
        end
        RADDR: if (m_arready) begin
          m_arvalid <= 1'b0;
          m_rready  <= 1'b1;
          idx       <= '0;
          state     <= RDATA;
        end
        // Every beat is drained even after a bad rresp.
        RDATA: if (m_rvalid) begin
          if (m_rresp != 2'b00) err <= 1'b1;
          if (r_last) begin
            m_rready <= 1'b0;
            idx      <= '0;
            if (err || m_rresp != 2'b00) begin
              state <= FIN;
            end else begin
              state     <= WADDR;
              m_awvalid <= 1'b1;
            end
          end else begin
            idx <= idx_inc;
          end
        end
        WADDR: if (m_awready) begin
          m_awvalid <= 1'b0;
          m_wvalid  <= 1'b1;
          m_wlast   <= (blen == 8'd0);
          state     <= WDATA;
        end
        WDATA: if (m_wready) begin
          if (m_wlast) begin
            m_wvalid <= 1'b0;
            m_wlast  <= 1'b0;
            m_bready <= 1'b1;
            state    <= WRESP;
          end else begin
            idx     <= idx_inc;
            m_wlast <= (idx_inc == blen[IW-1:0]);
          end
        end
        WRESP: if (m_bvalid) begin
          m_bready <= 1'b0;
          err      <= b_err;
          src      <= nsrc;
          dst      <= ndst;
          rem      <= nrem;
          blen     <= burst_len(nrem, nsrc[11:0], ndst[11:0]);
          if (nrem == '0 || b_err) begin
            state <= FIN;
          end else begin
            state     <= RADDR;
            m_arvalid <= 1'b1;
          end
        end
        FIN: begin
          done      <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
